// File: rtl/ram_bus_responder_pkg.sv
// ram_bus_responder_pkg: shared widths, FSM states and control-word bit positions
package ram_bus_responder_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_e;

    localparam int CW_NLMA = 11;
    localparam int CW_NLMD = 10;
    localparam int CW_NCE  = 9;
    localparam int CW_NLR  = 8;

endpackage

// File: rtl/ram_bus_responder_ram_dff_array.sv
// ram_dff_array: flop-based RAM, async clear, one write port and one combinational read port
module ram_dff_array
    import ram_bus_responder_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAM_BYTES = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [RAM_BYTES];

    // every word clears on reset; otherwise a single write per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_BYTES; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_bus_responder.sv
// ram_bus_responder: MAR/MDR/RAM responder for the CPU control bus with a byte-stream loader
module ram_bus_responder
    import ram_bus_responder_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAM_BYTES = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              n_lma,
    input  logic              n_lmd,
    input  logic              n_ce,
    input  logic              n_lr,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              prog_wrap,
    output logic              mode_prog
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_q, wrap_d;
    logic              run, load, we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, rdata;

    // state, address/data registers and loader pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            mar_q   <= '0;
            mdr_q   <= '0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    // prog_en alone selects the mode for the next cycle
    always_comb begin
        state_d = prog_en ? ST_PROG : ST_RUN;
    end

    // outputs decode from the registered state, so prog_ready is a registered signal
    always_comb begin
        run        = state_q == ST_RUN;
        mode_prog  = !run;
        prog_ready = !run;
        prog_ptr   = ptr_q;
        prog_wrap  = wrap_q;
        bus_oe     = run && !n_ce;
        bus_out    = bus_oe ? rdata : '0;
    end

    // CPU strobes act only in RUN; the loader owns the write port in PROG
    always_comb begin
        load   = prog_valid && prog_ready;
        mar_d  = (run && !n_lma) ? bus_in[ADDR_W-1:0] : mar_q;
        mdr_d  = (run && !n_lmd) ? bus_in : mdr_q;
        ptr_d  = (run && prog_en) ? '0 : load ? ptr_q + 1'b1 : ptr_q;
        wrap_d = load && (ptr_q == ADDR_W'(RAM_BYTES - 1));
        we     = run ? !n_lr : load;
        waddr  = run ? mar_q : ptr_q;
        wdata  = run ? mdr_q : prog_data;
    end

    ram_dff_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RAM_BYTES(RAM_BYTES)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(mar_q),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_ram_bus_responder.sv
// tb_ram_bus_responder: directed checks of CPU access, loader streaming and reset
module tb_ram_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_lma, n_lmd, n_ce, n_lr;
    logic       prog_en, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic [3:0] prog_ptr;
    logic       prog_wrap;
    logic       mode_prog;

    int assertions = 0;
    int failures   = 0;

    ram_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .n_lma     (n_lma),
        .n_lmd     (n_lmd),
        .n_ce      (n_ce),
        .n_lr      (n_lr),
        .prog_en   (prog_en),
        .prog_valid(prog_valid),
        .prog_data (prog_data),
        .prog_ready(prog_ready),
        .prog_ptr  (prog_ptr),
        .prog_wrap (prog_wrap),
        .mode_prog (mode_prog)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // loads MAR (with junk in the upper bus bits) and samples the zero-latency read
    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
        bus_in = {4'hA, a};
        n_lma  = 1'b0;
        tick();
        n_lma = 1'b1;
        n_ce  = 1'b0;
        #1;
        d  = bus_out;
        oe = bus_oe;
        n_ce = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        rst_n = 1'b0;
        {n_lma, n_lmd, n_ce, n_lr} = 4'hF;
        {prog_en, prog_valid} = 2'b00;
        bus_in = 8'h00;
        prog_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if ({bus_oe, bus_out, mode_prog, prog_ready, prog_wrap, prog_ptr} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: oe=%b out=%h mode=%b rdy=%b wrap=%b ptr=%h, required all 0",
                     bus_oe, bus_out, mode_prog, prog_ready, prog_wrap, prog_ptr);
        end
        rst_n = 1'b1;
        tick();
        assertions++;
        if (dut.mar_q !== 4'h0) begin
            failures++;
            $display("FAIL reset_mar: got %h, required 0", dut.mar_q);
        end
        for (int i = 0; i < 16; i++) begin
            cpu_read(4'(i), d, oe);
            assertions++;
            if (d !== 8'h00 || oe !== 1'b1) begin
                failures++;
                $display("FAIL reset_word[%0d]: got %h oe=%b, required 00 oe=1", i, d, oe);
            end
        end
    endtask

    task automatic test_cpu_write_read();
        bus_in = 8'h05;
        n_lma  = 1'b0;
        tick();
        n_lma  = 1'b1;
        bus_in = 8'hA7;
        n_lmd  = 1'b0;
        tick();
        n_lmd = 1'b1;
        n_lr  = 1'b0;
        tick();
        n_lr = 1'b1;
        n_ce = 1'b0;
        #1;
        assertions++;
        if (bus_out !== 8'hA7 || bus_oe !== 1'b1) begin
            failures++;
            $display("FAIL cpu_read_a7: got %h oe=%b, required a7 oe=1", bus_out, bus_oe);
        end
        n_ce = 1'b1;
        #1;
        assertions++;
        if (bus_out !== 8'h00 || bus_oe !== 1'b0) begin
            failures++;
            $display("FAIL ce_idle: got %h oe=%b, required 00 oe=0", bus_out, bus_oe);
        end
    endtask

    task automatic test_same_cycle_write_read();
        bus_in = 8'h3C;
        n_lmd  = 1'b0;
        tick();
        n_lmd = 1'b1;
        n_lr  = 1'b0;
        n_ce  = 1'b0;
        #1;
        assertions++;
        if (bus_out !== 8'hA7) begin
            failures++;
            $display("FAIL same_cycle_old: got %h, required a7", bus_out);
        end
        tick();
        n_lr = 1'b1;
        #1;
        assertions++;
        if (bus_out !== 8'h3C) begin
            failures++;
            $display("FAIL same_cycle_new: got %h, required 3c", bus_out);
        end
        n_ce = 1'b1;
    endtask

    task automatic test_prog_stream();
        int wraps = 0;
        bus_in = 8'hFF;
        n_lmd  = 1'b0;
        tick();
        n_lmd   = 1'b1;
        prog_en = 1'b1;
        tick();
        assertions++;
        if (mode_prog !== 1'b1 || prog_ready !== 1'b1 || prog_ptr !== 4'h0) begin
            failures++;
            $display("FAIL prog_entry: mode=%b rdy=%b ptr=%h, required 1 1 0", mode_prog, prog_ready, prog_ptr);
        end
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1;
            prog_data  = 8'h10 + 8'(i);
            tick();
            wraps += int'(prog_wrap);
            assertions++;
            if (prog_ptr !== 4'(i + 1)) begin
                failures++;
                $display("FAIL prog_ptr[%0d]: got %h, required %h", i, prog_ptr, 4'(i + 1));
            end
        end
        assertions++;
        if (wraps != 1 || prog_wrap !== 1'b1) begin
            failures++;
            $display("FAIL prog_wrap_pulse: count=%0d now=%b, required 1 1", wraps, prog_wrap);
        end
        prog_valid = 1'b0;
        tick();
        assertions++;
        if (prog_wrap !== 1'b0 || prog_ptr !== 4'h0) begin
            failures++;
            $display("FAIL prog_wrap_end: wrap=%b ptr=%h, required 0 0", prog_wrap, prog_ptr);
        end
    endtask

    task automatic test_prog_ignores_cpu();
        logic [7:0] d;
        logic       oe;
        {n_lma, n_lmd, n_ce, n_lr} = 4'h0;
        bus_in = 8'h3C;
        #1;
        assertions++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin
            failures++;
            $display("FAIL prog_bus_quiet: got %h oe=%b, required 00 oe=0", bus_out, bus_oe);
        end
        tick();
        tick();
        {n_lma, n_lmd, n_ce, n_lr} = 4'hF;
        prog_en    = 1'b0;
        prog_valid = 1'b1;
        prog_data  = 8'hEE;
        tick();
        prog_valid = 1'b0;
        assertions++;
        if (mode_prog !== 1'b0 || prog_ready !== 1'b0 || prog_ptr !== 4'h1) begin
            failures++;
            $display("FAIL prog_exit: mode=%b rdy=%b ptr=%h, required 0 0 1", mode_prog, prog_ready, prog_ptr);
        end
        for (int i = 0; i < 16; i++) begin
            cpu_read(4'(i), d, oe);
            assertions++;
            if (d !== ((i == 0) ? 8'hEE : 8'h10 + 8'(i))) begin
                failures++;
                $display("FAIL prog_word[%0d]: got %h, required %h", i, d, (i == 0) ? 8'hEE : 8'h10 + 8'(i));
            end
        end
        n_lr = 1'b0;
        tick();
        n_lr = 1'b1;
        n_ce = 1'b0;
        #1;
        assertions++;
        if (bus_out !== 8'hFF) begin
            failures++;
            $display("FAIL mdr_kept: got %h, required ff", bus_out);
        end
        n_ce = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        logic       oe;
        prog_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            prog_valid = 1'b1;
            prog_data  = 8'h80 + 8'(i);
            tick();
        end
        assertions++;
        if (prog_ptr !== 4'h7) begin
            failures++;
            $display("FAIL mid_load_ptr: got %h, required 7", prog_ptr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (prog_ready !== 1'b0 || mode_prog !== 1'b0 || prog_ptr !== 4'h0 || bus_oe !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: rdy=%b mode=%b ptr=%h oe=%b, required 0 0 0 0",
                     prog_ready, mode_prog, prog_ptr, bus_oe);
        end
        prog_en    = 1'b0;
        prog_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu_read(4'(i), d, oe);
            assertions++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL cleared_word[%0d]: got %h, required 00", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_same_cycle_write_read();
        test_prog_stream();
        test_prog_ignores_cpu();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
